noc_link_receiver: RTL and testbench
====================================

Name: noc_link_receiver

Overview:
- Receive end of the credit-based NoC link (enable / data / credit).
- Buffers incoming flits in a DEPTH-entry FIFO and presents them to the downstream router stage or local sink through a valid/ready handshake.
- Returns one single-cycle credit pulse for every flit drained.
- The paired link sender resets its credit counter to DEPTH, so this block never needs more than DEPTH slots.

Parameters:
- FLIT_W, 16, flit width; must match link data width.
- DEPTH, 4, buffer entries; equals the sender's initial credit count; power of two, at least 2.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  link flit-valid from the sender; one flit per high cycle.
- data  input  FLIT_W  link flit payload; sampled when enable=1.
- credit  output  1  one-cycle pulse per freed buffer slot, returned to the sender.
- out_valid  output  1  head flit available.
- out_data  output  FLIT_W  head flit payload.
- out_ready  input  1  downstream accepts head flit.
- occupancy  output  $clog2(DEPTH)+1  current flit count, 0..DEPTH.
- overflow  output  1  sticky error: flit arrived with buffer full and no pop.

Behaviour:
- Reset (rst=1 at posedge):
  - Read/write pointers and count cleared.
  - credit=0, out_valid=0, occupancy=0, overflow=0, out_data=0.
  - Flits arriving during reset are ignored.
- push = enable. pop = out_valid & out_ready.
- Push: data written at the write pointer; pointer wraps from DEPTH-1 to 0.
- Pop: read pointer advances with the same wrap; out_data shows the new head.
- Latency and ordering:
  - No bypass. A flit pushed into an empty buffer at edge N gives out_valid=1 from edge N+1.
  - Order is strictly FIFO.
- out_data is driven from the head entry whenever out_valid=1. It is don't-care when out_valid=0, but the bench must not check it then.
- Credit return:
  - credit is registered: credit=1 for exactly the cycle after each pop, otherwise 0.
  - Back-to-back pops produce back-to-back pulses, one pulse per pop, never merged.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
- Boundary conditions:
  - Full with push and pop together: both accepted. Count stays DEPTH, credit pulses next cycle, no overflow.
  - Full with push and no pop: flit dropped, storage and pointers unchanged, overflow set and held until rst. This is a protocol violation by the sender.
  - Empty: out_valid=0; out_ready is ignored; no credit is generated.
  - Empty with push: accepted; out_valid=1 next cycle.
  - out_ready high while out_valid low: no effect.
- Reset mid-operation: buffered flits are discarded and no credits are returned for them. The sender is reset by the same rst and restores DEPTH credits, so credit accounting stays consistent.
- Invariant checked by assertion: occupancy + credits in flight + sender credits == DEPTH.

Decomposition:
- Shared noc_pkg:
  - FLIT_W constant (16).
  - flit_t typedef (logic [FLIT_W-1:0]).
  - LINK_DEPTH default (4), also used by the sender's credit counter reset value.
- One natural sub-module: noc_flit_fifo.
  - Parameterised storage, pointers and count.
  - Provides full/empty flags and push/pop with simultaneous-access rules.
  - Reusable by router input ports.
- noc_link_receiver wraps noc_flit_fifo and adds the credit register and the overflow flag.

Test Plan:
- Reset then single flit: push 16'hA5A5 with out_ready=0 -> out_valid=1 next cycle, out_data=16'hA5A5, occupancy=1. Then raise out_ready for one cycle -> credit=1 exactly one cycle later, occupancy=0, out_valid=0.
- Fill to DEPTH=4 with 16'h0001..16'h0004, out_ready=0 -> occupancy=4, no credit pulses. Then drain with out_ready=1 -> outputs 1,2,3,4 in order and four consecutive credit pulses.
- Full plus simultaneous push/pop: buffer holds 1..4, push 16'h0005 while popping -> head becomes 2, occupancy stays 4, overflow=0, one credit pulse. Later drain yields 2,3,4,5.
- Overflow: buffer full, out_ready=0, push 16'hDEAD -> flit dropped, overflow=1 and stays 1. Drained contents are unchanged and contain no 16'hDEAD.
- Pointer wrap: stream 12 flits with push and pop interleaved, occupancy kept between 1 and 3 -> all 12 emerge in order, exactly 12 credit pulses, no overflow.
- Reset mid-operation: occupancy=3, assert rst for one cycle -> occupancy=0, out_valid=0, no credit pulse for the discarded flits. A post-reset push of 16'h1234 emerges correctly.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC link definitions: flit format and the default link buffer depth.
// LINK_DEPTH is also the reset value of the paired sender's credit counter.
package noc_pkg;

   localparam int FLIT_W     = 16;
   localparam int LINK_DEPTH = 4;

   typedef logic [FLIT_W-1:0] flit_t;

   // Width of a counter that must hold 0..depth inclusive.
   function automatic int cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/noc_flit_fifo.sv
// Flit FIFO with full/empty flags and simultaneous push/pop.
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle; otherwise it is refused and storage/pointers are left untouched.
// Head data reads as zero while empty so the output is clean after reset.
module noc_flit_fifo
   import noc_pkg::*;
#(
   parameter int W     = FLIT_W,
   parameter int DEPTH = LINK_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic [W-1:0]             wdata_i,
   input  logic                     pop_i,
   output logic [W-1:0]             rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic                     push_ok_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [AW:0]   count_q, count_d;
   logic          wr_en, rd_en;

   assign empty_o   = (count_q == '0);
   assign full_o    = (count_q == FULL_CNT);
   assign rd_en     = pop_i & ~empty_o;
   // Full slot is freed by a same-cycle pop, so the write may proceed.
   assign wr_en     = push_i & (~full_o | rd_en);
   assign push_ok_o = wr_en;
   assign count_o   = count_q;
   assign rdata_o   = empty_o ? '0 : mem_q[rptr_q];

   // Next-state for pointers and count; pointers wrap naturally (DEPTH is 2^n).
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (wr_en) wptr_d = wptr_q + PTR_ONE;
      if (rd_en) rptr_d = rptr_q + PTR_ONE;
      unique case ({wr_en, rd_en})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // Storage write; contents need no reset because empty masks the head.
   always_ff @(posedge clk) begin
      if (!rst && wr_en) mem_q[wptr_q] <= wdata_i;
   end

   // Pointer and count registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/noc_link_receiver.sv
// Receive end of the credit-based NoC link. Buffers flits from the sender,
// hands them downstream with valid/ready, and returns one registered credit
// pulse per drained flit. A flit arriving while full without a pop is a
// sender protocol violation: it is dropped and a sticky overflow is raised.
module noc_link_receiver
   import noc_pkg::*;
#(
   parameter int FLIT_W = noc_pkg::FLIT_W,
   parameter int DEPTH  = LINK_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable,
   input  logic [FLIT_W-1:0]        data,
   output logic                     credit,
   output logic                     out_valid,
   output logic [FLIT_W-1:0]        out_data,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   occupancy,
   output logic                     overflow
);

   logic pop;
   logic full, empty, push_ok;
   logic credit_q, credit_d;
   logic overflow_q, overflow_d;

   noc_flit_fifo #(
      .W     (FLIT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push_i    (enable),
      .wdata_i   (data),
      .pop_i     (pop),
      .rdata_o   (out_data),
      .full_o    (full),
      .empty_o   (empty),
      .push_ok_o (push_ok),
      .count_o   (occupancy)
   );

   assign out_valid = ~empty;
   assign pop       = out_valid & out_ready;

   // One credit per pop, returned the following cycle; never merged.
   assign credit_d   = pop;
   // Dropped flit: push refused because the buffer was full with no pop.
   assign overflow_d = overflow_q | (enable & ~push_ok);

   // Credit pulse and sticky overflow registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         credit_q   <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         credit_q   <= credit_d;
         overflow_q <= overflow_d;
      end
   end

   assign credit   = credit_q;
   assign overflow = overflow_q;

   // full is only consumed through push_ok; keep it observable for reuse.
   logic unused_full;
   assign unused_full = full;

endmodule

// File: tb/tb_noc_link_receiver.sv
// Randomised + directed bench for noc_link_receiver against a queue model.
module tb_noc_link_receiver;

   localparam int W = 16;
   localparam int D = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic [W-1:0]  data;
   logic          credit;
   logic          out_valid;
   logic [W-1:0]  out_data;
   logic          out_ready;
   logic [$clog2(D):0] occupancy;
   logic          overflow;

   noc_link_receiver #(.FLIT_W(W), .DEPTH(D)) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .data      (data),
      .credit    (credit),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .occupancy (occupancy),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   // Reference model
   logic [W-1:0] mq[$];
   bit  m_credit;
   bit  m_ovf;
   int  s_cred;       // sender's credit counter
   int  credit_seen;  // observed credit pulses
   int  checks = 0;
   int  errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Compare every DUT output with the model (called #1 after an edge).
   task automatic check_all();
      chk("occupancy", 32'(occupancy), 32'(mq.size()));
      chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) chk("out_data", 32'(out_data), 32'(mq[0]));
      chk("credit", 32'(credit), 32'(m_credit));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      if (!m_ovf) chk("invariant", 32'(mq.size() + int'(m_credit) + s_cred), 32'(D));
   endtask

   // One clock with given inputs; model advanced by FIFO/credit rules.
   task automatic cyc(input bit en, input logic [W-1:0] d, input bit rdy, input bit r = 1'b0);
      bit pop;
      rst = r; enable = en; data = d; out_ready = rdy;
      @(posedge clk);
      #1;
      if (r) begin
         mq.delete(); m_credit = 0; m_ovf = 0; s_cred = D;
      end else begin
         // sender sees the credit wire at this edge and spends one per flit
         s_cred = s_cred + int'(m_credit) - int'(en);
         pop = (mq.size() > 0) && rdy;
         if (pop) void'(mq.pop_front());
         if (en) begin
            if (mq.size() < D) mq.push_back(d);
            else m_ovf = 1;
         end
         m_credit = pop;
      end
      if (credit) credit_seen++;
      rst = 0; enable = 0; out_ready = 0;
      check_all();
   endtask

   initial begin
      rst = 1; enable = 0; data = '0; out_ready = 0;
      mq.delete(); m_credit = 0; m_ovf = 0; s_cred = D; credit_seen = 0;

      // reset state
      cyc(0, '0, 0, 1);
      chk("rst_out_data", 32'(out_data), 32'h0);

      // single flit, then drain it
      cyc(1, 16'hA5A5, 0);
      cyc(0, '0, 1);
      chk("single_credit", 32'(credit), 32'h1);
      cyc(0, '0, 0);

      // fill 1..4, no credits, then drain in order
      credit_seen = 0;
      for (int i = 1; i <= 4; i++) cyc(1, W'(i), 0);
      chk("fill_no_credit", 32'(credit_seen), 32'h0);
      for (int i = 0; i < 5; i++) cyc(0, '0, 1);
      chk("drain_credits", 32'(credit_seen), 32'h4);

      // full with simultaneous push/pop
      for (int i = 1; i <= 4; i++) cyc(1, W'(i), 0);
      cyc(1, 16'h0005, 1);
      chk("full_pp_head", 32'(out_data), 32'h2);
      for (int i = 0; i < 5; i++) cyc(0, '0, 1);

      // overflow: dropped flit, sticky flag
      for (int i = 1; i <= 4; i++) cyc(1, W'(16'h10 + i), 0);
      cyc(1, 16'hDEAD, 0);
      chk("ovf_set", 32'(overflow), 32'h1);
      for (int i = 0; i < 6; i++) begin
         if (out_valid) chk("no_dead", 32'(out_data != 16'hDEAD), 32'h1);
         cyc(0, '0, 1);
      end
      chk("ovf_sticky", 32'(overflow), 32'h1);

      // reset mid-operation with 3 flits buffered
      cyc(0, '0, 0, 1);
      for (int i = 1; i <= 3; i++) cyc(1, W'(16'h20 + i), 0);
      credit_seen = 0;
      cyc(0, '0, 1, 1);
      cyc(0, '0, 0);
      chk("rst_no_credit", 32'(credit_seen), 32'h0);
      cyc(1, 16'h1234, 0);
      cyc(0, '0, 1);
      cyc(0, '0, 0);

      // pointer wrap: 12 flits, occupancy held in 1..3
      credit_seen = 0;
      cyc(1, 16'h0100, 0);
      cyc(1, 16'h0101, 0);
      for (int i = 2; i < 12; i++) cyc(1, W'(16'h0100 + i), 1);
      cyc(0, '0, 1);
      cyc(0, '0, 1);
      cyc(0, '0, 0);
      chk("wrap_credits", 32'(credit_seen), 32'd12);

      // randomised traffic from a well-behaved sender
      for (int n = 0; n < 2000; n++) begin
         bit en;
         en = (s_cred > 0) && ($urandom_range(0, 2) != 0);
         cyc(en, W'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 199) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "timeout");
   end

endmodule
